// File: rtl/rtc_tick_gen_pkg.sv
// rtc_tick_gen_pkg: shared helpers for the RTC tick generator
package rtc_tick_gen_pkg;
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rtc_tick_gen_sync_ff.sv
// sync_ff: generic N-stage synchroniser for asynchronous single-bit inputs
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else r <= {r[STAGES-2:0], d};
  end
  assign q = r[STAGES-1];
endmodule

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: synchronise, glitch-filter and prescale a raw RTC input into clk ticks
module rtc_tick_gen
  import rtc_tick_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 3,
  parameter int DIV         = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rtc_i,
  input  logic en_i,
  output logic tick_o,
  output logic rtc_level_o,
  output logic alive_o
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int PW = cnt_w(DIV);
  localparam int AW = $clog2(TIMEOUT + 1);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("FILTER must be >= 1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("DIV must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end
  logic s, lvl, lvl_q, rise, any_edge;
  logic [FW-1:0] fcnt;
  logic [PW-1:0] pcnt;
  logic [AW-1:0] acnt, acnt_n;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d  (rtc_i),
    .q  (s)
  );
  assign rise        = lvl & ~lvl_q;
  assign any_edge    = lvl ^ lvl_q;
  assign rtc_level_o = lvl;
  // alive_o is derived from the next count so it drops on the edge acnt saturates
  always_comb begin
    acnt_n = any_edge ? '0 : (acnt == AW'(TIMEOUT)) ? acnt : acnt + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl     <= 1'b0;
      lvl_q   <= 1'b0;
      fcnt    <= '0;
      pcnt    <= '0;
      acnt    <= AW'(TIMEOUT);
      tick_o  <= 1'b0;
      alive_o <= 1'b0;
    end else begin
      lvl_q <= lvl;
      if (s == lvl) fcnt <= '0;
      else if (fcnt == FW'(FILTER - 1)) begin
        lvl  <= ~lvl;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      tick_o  <= en_i & rise & (pcnt == PW'(DIV - 1));
      pcnt    <= !en_i ? '0 : !rise ? pcnt : (pcnt == PW'(DIV - 1)) ? '0 : pcnt + 1'b1;
      acnt    <= acnt_n;
      alive_o <= acnt_n < AW'(TIMEOUT);
    end
  end
endmodule

// File: tb/tb_rtc_tick_gen.sv
// tb_rtc_tick_gen: directed table plus sequences for filter, prescaler, enable and alive timing
module tb_rtc_tick_gen;
  logic clk = 1'b0, rst = 1'b1, rtc = 1'b0, en = 1'b1;
  logic tick_a, lvl_a, alive_a, tick_b, lvl_b, alive_b;
  int n_vec = 0, n_bad = 0, cnt_a = 0, cnt_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0, lmax_a = 1'b0;

  typedef struct packed {
    logic rst, rtc, en, tick_a, lvl_a, alive_a, tick_b, alive_b;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  rtc_tick_gen dut_a (
    .clk_i(clk), .rst_i(rst), .rtc_i(rtc), .en_i(en),
    .tick_o(tick_a), .rtc_level_o(lvl_a), .alive_o(alive_a)
  );
  rtc_tick_gen #(.DIV(4), .TIMEOUT(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .rtc_i(rtc), .en_i(en),
    .tick_o(tick_b), .rtc_level_o(lvl_b), .alive_o(alive_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_a) begin
      chk("b2b_tick_a", int'(prev_a), 0);
      cnt_a++;
    end
    if (tick_b) begin
      chk("b2b_tick_b", int'(prev_b), 0);
      cnt_b++;
    end
    prev_a = tick_a;
    prev_b = tick_b;
    lmax_a = lmax_a | lvl_a;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rtc = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    lmax_a = 1'b0;
  endtask

  task automatic period(input int hi, input int lo, input int en_off = -1);
    for (int k = 1; k <= hi + lo; k++) begin
      rtc = (k <= hi);
      en  = (k != en_off);
      step();
    end
    en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = '{1, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 3; i < 7; i++) tbl[i] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 1, 0, 1, 0, 0, 0};
    tbl[8] = '{0, 1, 1, 1, 1, 1, 0, 1};
    tbl[9] = '{0, 1, 1, 0, 1, 1, 0, 1};
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      rtc = tbl[i].rtc;
      en  = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_tick_a", i), int'(tick_a), int'(tbl[i].tick_a));
      chk($sformatf("tbl%0d_lvl_a", i), int'(lvl_a), int'(tbl[i].lvl_a));
      chk($sformatf("tbl%0d_alive_a", i), int'(alive_a), int'(tbl[i].alive_a));
      chk($sformatf("tbl%0d_tick_b", i), int'(tick_b), int'(tbl[i].tick_b));
      chk($sformatf("tbl%0d_alive_b", i), int'(alive_b), int'(tbl[i].alive_b));
    end

    do_reset(2);
    period(2, 10);
    chk("glitch2_level", int'(lmax_a), 0);
    chk("glitch2_ticks", cnt_a, 0);
    period(3, 10);
    chk("pulse3_level", int'(lmax_a), 1);
    chk("pulse3_ticks", cnt_a, 1);

    do_reset(2);
    for (int p = 1; p <= 10; p++) begin
      period(4, 4);
      chk($sformatf("div4_p%0d", p), cnt_b, p / 4);
    end
    chk("div1_ticks", cnt_a, 10);

    do_reset(2);
    for (int p = 0; p < 3; p++) period(4, 4);
    chk("gate_pre", cnt_b, 0);
    en = 1'b0;
    step();
    en = 1'b1;
    for (int p = 1; p <= 4; p++) period(4, 4);
    chk("gate_post4", cnt_b, 1);

    do_reset(2);
    for (int p = 0; p < 3; p++) period(4, 4);
    period(4, 4, 6);
    chk("en_low_rise_b", cnt_b, 0);
    chk("en_low_rise_a", cnt_a, 3);
    for (int p = 0; p < 3; p++) period(4, 4);
    chk("en_low_after3", cnt_b, 0);
    period(4, 4);
    chk("en_low_after4", cnt_b, 1);

    do_reset(2);
    chk("alive_reset", int'(alive_b), 0);
    rtc = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 5) chk("alive_pre_edge", int'(alive_b), 0);
      if (k == 6) chk("alive_rise", int'(alive_b), 1);
      if (k == 21) chk("alive_hold", int'(alive_b), 1);
      if (k == 22) begin
        chk("alive_timeout", int'(alive_b), 0);
        chk("alive_long_to", int'(alive_a), 1);
      end
    end
    rtc = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) chk("alive_fall_pre", int'(alive_b), 0);
      if (k == 6) chk("alive_reraise", int'(alive_b), 1);
    end

    do_reset(2);
    for (int p = 0; p < 3; p++) period(4, 4);
    chk("mid_pre", cnt_b, 0);
    do_reset(1);
    chk("mid_alive_b", int'(alive_b), 0);
    chk("mid_alive_a", int'(alive_a), 0);
    chk("mid_level", int'(lvl_b), 0);
    for (int p = 0; p < 3; p++) period(4, 4);
    chk("mid_after3", cnt_b, 0);
    period(4, 4);
    chk("mid_after4", cnt_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
